// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer fill controller.
// Contents: framebuffer geometry, coordinate widths, the fill FSM state type
// and the fill command record.
package fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 200;
    localparam int FB_DEPTH  = 8;

    localparam int X_W = 9;
    localparam int Y_W = 8;

    // Exclusive limits, one bit wider than a coordinate so that "end" values
    // (x0+w, y0+h) compare against them without overflow.
    localparam logic [X_W:0] X_LIMIT = (X_W+1)'(FB_WIDTH);
    localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(FB_HEIGHT);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [X_W-1:0]      w;
        logic [Y_W-1:0]      h;
        logic [FB_DEPTH-1:0] color;
    } fill_cmd_t;

endpackage

// File: rtl/fb_rect_walker.sv
// Row-major rectangle walker.
// Holds the current pixel position of a fill and steps it on i_advance.
// i_load presents a new rectangle; during the load cycle the outputs already
// show the origin so the controller can issue the first write immediately.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   i_load            latch origin and exclusive ends
//   i_x0, i_y0        rectangle origin
//   i_x_end, i_y_end  exclusive end coordinates (one bit wider)
//   i_advance         step to the next pixel
//   o_cur_x, o_cur_y  current pixel
//   o_last            current pixel is the final one of the rectangle
module fb_rect_walker
    import fb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           i_load,
    input  logic [X_W-1:0] i_x0,
    input  logic [Y_W-1:0] i_y0,
    input  logic [X_W:0]   i_x_end,
    input  logic [Y_W:0]   i_y_end,
    input  logic           i_advance,
    output logic [X_W-1:0] o_cur_x,
    output logic [Y_W-1:0] o_cur_y,
    output logic           o_last
);

    logic [X_W-1:0] r_x0;
    logic [X_W-1:0] r_cur_x;
    logic [Y_W-1:0] r_cur_y;
    logic [X_W:0]   r_x_end;
    logic [Y_W:0]   r_y_end;

    logic [X_W-1:0] w_x0;
    logic [X_W:0]   w_x_end;
    logic [Y_W:0]   w_y_end;
    logic           w_row_end;

    always_comb begin
        w_x0      = i_load ? i_x0    : r_x0;
        w_x_end   = i_load ? i_x_end : r_x_end;
        w_y_end   = i_load ? i_y_end : r_y_end;
        o_cur_x   = i_load ? i_x0    : r_cur_x;
        o_cur_y   = i_load ? i_y0    : r_cur_y;
        w_row_end = (({1'b0, o_cur_x} + 1'b1) == w_x_end);
        o_last    = w_row_end && (({1'b0, o_cur_y} + 1'b1) == w_y_end);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x0    <= '0;
            r_cur_x <= '0;
            r_cur_y <= '0;
            r_x_end <= '0;
            r_y_end <= '0;
        end else begin
            if (i_load) begin
                r_x0    <= i_x0;
                r_x_end <= i_x_end;
                r_y_end <= i_y_end;
            end
            if (i_advance) begin
                if (w_row_end) begin
                    r_cur_x <= w_x0;
                    r_cur_y <= o_cur_y + 1'b1;
                end else begin
                    r_cur_x <= o_cur_x + 1'b1;
                    r_cur_y <= o_cur_y;
                end
            end else if (i_load) begin
                r_cur_x <= i_x0;
                r_cur_y <= i_y0;
            end
        end
    end

endmodule

// File: rtl/fb_fill_controller.sv
// Rectangle-fill sequencer and write-port arbiter for a 320x200x8 framebuffer.
// Fill commands are walked row-major and emitted one pixel per cycle; a host
// single-pixel stream shares the write port, alternating with the fill when
// both compete. All write outputs are registered (grant at N -> write at N+1).
// Configuration macro FB_FILL_CLIP_EN: when defined, rectangles are clipped to
// the framebuffer; when undefined, out-of-bounds commands are rejected with a
// one-cycle cmd_error pulse.
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_*         fill command handshake and fields
//   pix_valid/pix_ready, pix_*         host pixel handshake and fields
//   fb_write_enable/x/y/data           framebuffer write port
//   busy, done, cmd_error              status
module fb_fill_controller
    import fb_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [X_W-1:0]      cmd_x,
    input  logic [Y_W-1:0]      cmd_y,
    input  logic [X_W-1:0]      cmd_w,
    input  logic [Y_W-1:0]      cmd_h,
    input  logic [FB_DEPTH-1:0] cmd_color,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [X_W-1:0]      pix_x,
    input  logic [Y_W-1:0]      pix_y,
    input  logic [FB_DEPTH-1:0] pix_data,
    output logic                fb_write_enable,
    output logic [X_W-1:0]      fb_write_x,
    output logic [Y_W-1:0]      fb_write_y,
    output logic [FB_DEPTH-1:0] fb_write_data,
    output logic                busy,
    output logic                done,
    output logic                cmd_error
);

    fill_state_t         r_state, w_state_next;
    logic                r_busy, r_last_fill, r_done, r_err, r_we;
    logic [X_W-1:0]      r_wx;
    logic [Y_W-1:0]      r_wy;
    logic [FB_DEPTH-1:0] r_wd, r_color;

    fill_cmd_t           w_cmd;
    logic [X_W:0]        w_x_sum, w_x_end;
    logic [Y_W:0]        w_y_sum, w_y_end;
    logic                w_reject, w_zero, w_cmd_acc, w_pix_acc, w_pix_write;
    logic                w_start, w_fill_grant, w_last;
    logic [X_W-1:0]      w_cur_x;
    logic [Y_W-1:0]      w_cur_y;

    always_comb begin
        w_cmd   = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
        w_x_sum = {1'b0, w_cmd.x} + {1'b0, w_cmd.w};
        w_y_sum = {1'b0, w_cmd.y} + {1'b0, w_cmd.h};
`ifdef FB_FILL_CLIP_EN
        w_x_end  = (w_x_sum > X_LIMIT) ? X_LIMIT : w_x_sum;
        w_y_end  = (w_y_sum > Y_LIMIT) ? Y_LIMIT : w_y_sum;
        w_reject = 1'b0;
        // Also covers w=0, h=0 and an origin outside the framebuffer.
        w_zero   = (w_x_end <= {1'b0, w_cmd.x}) || (w_y_end <= {1'b0, w_cmd.y});
`else
        w_x_end  = w_x_sum;
        w_y_end  = w_y_sum;
        w_reject = (w_x_sum > X_LIMIT) || (w_y_sum > Y_LIMIT);
        w_zero   = (w_cmd.w == '0) || (w_cmd.h == '0);
`endif
        // Commands wait until the final write of the previous fill has issued.
        cmd_ready   = (r_state == IDLE) && !r_busy;
        pix_ready   = (r_state == IDLE) || r_last_fill;
        w_cmd_acc   = cmd_valid && cmd_ready;
        w_pix_acc   = pix_valid && pix_ready;
        w_pix_write = w_pix_acc && ({1'b0, pix_x} < X_LIMIT) && ({1'b0, pix_y} < Y_LIMIT);
        w_start     = w_cmd_acc && !w_reject && !w_zero;

        // In IDLE the first fill pixel goes out in the accept cycle unless a
        // host pixel takes the port; in FILL the fill gets every slot the
        // host does not win.
        if (r_state == IDLE) begin
            w_fill_grant = w_start && !w_pix_acc;
        end else begin
            w_fill_grant = !w_pix_acc;
        end

        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_start && !(w_fill_grant && w_last)) w_state_next = FILL;
            FILL: if (w_fill_grant && w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    fb_rect_walker u_walker (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_start),
        .i_x0      (w_cmd.x),
        .i_y0      (w_cmd.y),
        .i_x_end   (w_x_end),
        .i_y_end   (w_y_end),
        .i_advance (w_fill_grant),
        .o_cur_x   (w_cur_x),
        .o_cur_y   (w_cur_y),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_last_fill <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_wx        <= '0;
            r_wy        <= '0;
            r_wd        <= '0;
            r_color     <= '0;
        end else begin
            r_state <= w_state_next;
            // busy stays up through the cycle carrying the final fill write.
            r_busy  <= (w_state_next == FILL) || w_fill_grant;
            if (w_fill_grant) begin
                r_last_fill <= 1'b1;
            end else if (w_pix_acc) begin
                r_last_fill <= 1'b0;
            end
            if (w_start) r_color <= w_cmd.color;
            r_done <= (w_fill_grant && w_last) || (w_cmd_acc && !w_reject && w_zero);
            r_err  <= w_cmd_acc && w_reject;
            r_we   <= w_fill_grant || w_pix_write;
            if (w_fill_grant) begin
                r_wx <= w_cur_x;
                r_wy <= w_cur_y;
                r_wd <= w_start ? w_cmd.color : r_color;
            end else if (w_pix_write) begin
                r_wx <= pix_x;
                r_wy <= pix_y;
                r_wd <= pix_data;
            end
        end
    end

    assign fb_write_enable = r_we;
    assign fb_write_x      = r_wx;
    assign fb_write_y      = r_wy;
    assign fb_write_data   = r_wd;
    assign busy            = r_busy;
    assign done            = r_done;
    assign cmd_error       = r_err;

endmodule

// File: tb/tb_fb_fill_controller.sv
// Self-checking bench for fb_fill_controller: reset state, table of fill
// commands, hand-written timing sequences and a randomized mixed stream
// checked against a rectangle-level reference model.
module tb_fb_fill_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready;
    logic [8:0] cmd_x, cmd_w;
    logic [7:0] cmd_y, cmd_h, cmd_color;
    logic       pix_valid, pix_ready;
    logic [8:0] pix_x;
    logic [7:0] pix_y, pix_data;
    logic       fb_write_enable;
    logic [8:0] fb_write_x;
    logic [7:0] fb_write_y, fb_write_data;
    logic       busy, done, cmd_error;

    fb_fill_controller dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .fb_write_enable(fb_write_enable), .fb_write_x(fb_write_x),
        .fb_write_y(fb_write_y), .fb_write_data(fb_write_data),
        .busy(busy), .done(done), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mon_done = 0;
    int mon_err = 0;
    int exp_done = 0;
    int exp_err = 0;
    logic [24:0] got_all[$];
    logic [24:0] exp_fill[$];
    logic [24:0] exp_pix[$];

    always @(negedge clk) begin
        if (fb_write_enable) got_all.push_back({fb_write_x, fb_write_y, fb_write_data});
        if (done) mon_done++;
        if (cmd_error) mon_err++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the set of pixels a command paints, row-major.
    task automatic model_cmd(input int x, input int y, input int w, input int h, input logic [7:0] c);
        int xe, ye;
        xe = x + w;
        ye = y + h;
`ifdef FB_FILL_CLIP_EN
        if (xe > 320) xe = 320;
        if (ye > 200) ye = 200;
`else
        if (xe > 320 || ye > 200) begin
            exp_err++;
            return;
        end
`endif
        if (xe > x && ye > y) begin
            for (int yy = y; yy < ye; yy++)
                for (int xx = x; xx < xe; xx++)
                    exp_fill.push_back({9'(xx), 8'(yy), c});
        end
        exp_done++;
    endtask

    task automatic model_pix(input int x, input int y, input logic [7:0] d);
        if (x < 320 && y < 200) exp_pix.push_back({9'(x), 8'(y), d});
    endtask

    task automatic clear_all();
        got_all.delete(); exp_fill.delete(); exp_pix.delete();
        mon_done = 0; mon_err = 0; exp_done = 0; exp_err = 0;
    endtask

    task automatic drive_cmd(input int x, input int y, input int w, input int h, input logic [7:0] c);
        cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = c;
        cmd_valid = 1'b1;
    endtask

    task automatic send_cmd(input int x, input int y, input int w, input int h, input logic [7:0] c);
        int k;
        k = 0;
        while (!cmd_ready && k < 1000) begin step(); k++; end
        if (k >= 1000) check("cmd_ready_timeout", 1, 0);
        drive_cmd(x, y, w, h, c);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || !cmd_ready || fb_write_enable) && k < 2000) begin step(); k++; end
        if (k >= 2000) check("idle_timeout", 1, 0);
        step(); step();
    endtask

    task automatic compare_q(input string name, input logic [24:0] got[$], input logic [24:0] exp[$]);
        check({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            if (got[i] !== exp[i]) begin
                check({name, "_entry"}, got[i], exp[i]);
                break;
            end
        end
    endtask

    typedef struct {
        int x, y, w, h;
        logic [7:0] c;
        int n, nd, ne;
    } vec_t;
    vec_t vt[8];

    initial begin
        int acc;
        logic [24:0] gf[$];
        logic [24:0] gp[$];

        vt[0] = '{10, 5, 3, 2, 8'hAA, 6, 1, 0};
        vt[1] = '{0, 0, 0, 10, 8'h01, 0, 1, 0};
`ifdef FB_FILL_CLIP_EN
        vt[2] = '{318, 199, 5, 4, 8'hC3, 2, 1, 0};
        vt[7] = '{330, 10, 0, 2, 8'h12, 0, 1, 0};
`else
        vt[2] = '{318, 199, 5, 4, 8'hC3, 0, 0, 1};
        vt[7] = '{330, 10, 0, 2, 8'h12, 0, 0, 1};
`endif
        vt[3] = '{0, 0, 1, 1, 8'h80, 1, 1, 0};
        vt[4] = '{300, 190, 20, 10, 8'h9E, 200, 1, 0};
        vt[5] = '{5, 5, 4, 0, 8'h81, 0, 1, 0};
        vt[6] = '{319, 0, 1, 200, 8'hF0, 200, 1, 0};

        reset = 1'b0;
        cmd_valid = 0; cmd_x = 0; cmd_y = 0; cmd_w = 0; cmd_h = 0; cmd_color = 0;
        pix_valid = 0; pix_x = 0; pix_y = 0; pix_data = 0;
        repeat (3) step();
        check("reset_state", {cmd_ready, pix_ready, fb_write_enable, busy, done, cmd_error}, 6'b110000);
        reset = 1'b1;
        step();

        // Table of standalone fills.
        for (int i = 0; i < 8; i++) begin
            clear_all();
            model_cmd(vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].c);
            send_cmd(vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].c);
            wait_idle();
            $display("vec %0d: cmd (%0d,%0d,%0d,%0d) writes=%0d done=%0d err=%0d",
                     i, vt[i].x, vt[i].y, vt[i].w, vt[i].h, got_all.size(), mon_done, mon_err);
            check($sformatf("vec%0d_writes", i), got_all.size(), vt[i].n);
            check($sformatf("vec%0d_done", i), mon_done, vt[i].nd);
            check($sformatf("vec%0d_err", i), mon_err, vt[i].ne);
            compare_q($sformatf("vec%0d_pixels", i), got_all, exp_fill);
        end

        // Exact cycle timing of a 3x2 fill.
        drive_cmd(10, 5, 3, 2, 8'hAA);
        check("t1_ready_before", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t1_cycle%0d", k + 1),
                  {fb_write_enable, fb_write_x, fb_write_y, fb_write_data, done, busy, cmd_ready},
                  {1'b1, 9'(10 + k % 3), 8'(5 + k / 3), 8'hAA, (k == 5), 1'b1, 1'b0});
            step();
        end
        check("t1_after", {fb_write_enable, done, busy, cmd_ready}, 4'b0001);
        $display("t1: timed 3x2 fill done");

        // Zero-width fill: done next cycle, no write, ready stays high.
        drive_cmd(0, 0, 0, 10, 8'h44);
        step();
        cmd_valid = 1'b0;
        check("zero_n1", {done, fb_write_enable, cmd_ready}, 3'b101);
        step();
        check("zero_n2", done, 1'b0);
        $display("zero-area fill done");

        // Edge fill at the bottom-right corner.
        drive_cmd(318, 199, 5, 4, 8'h3C);
        step();
        cmd_valid = 1'b0;
`ifdef FB_FILL_CLIP_EN
        check("edge_n1", {fb_write_enable, fb_write_x, fb_write_y, done}, {1'b1, 9'd318, 8'd199, 1'b0});
        step();
        check("edge_n2", {fb_write_enable, fb_write_x, fb_write_y, done}, {1'b1, 9'd319, 8'd199, 1'b1});
        step();
        check("edge_n3", fb_write_enable, 1'b0);
`else
        check("edge_n1", {cmd_error, fb_write_enable, done}, 3'b100);
        step();
        check("edge_n2", {cmd_error, fb_write_enable, done}, 3'b000);
`endif
        wait_idle();
        $display("edge fill done");

        // Fill competing with a held host pixel stream.
        clear_all();
        model_cmd(10, 5, 3, 2, 8'hAA);
        pix_x = 0; pix_y = 0; pix_data = 8'h11; pix_valid = 1'b1;
        drive_cmd(10, 5, 3, 2, 8'hAA);
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            if (pix_valid && pix_ready) acc++;
            step();
            cmd_valid = 1'b0;
            if (k > 1 && !busy) break;
        end
        pix_valid = 1'b0;
        step(); step();
        check("arb_len", got_all.size() >= 12, 1'b1);
        if (got_all.size() >= 12) begin
            for (int i = 0; i < 12; i++) begin
                if (i % 2 == 0) check($sformatf("arb_slot%0d", i), got_all[i], {9'd0, 8'd0, 8'h11});
                else check($sformatf("arb_slot%0d", i), got_all[i], exp_fill[(i - 1) / 2]);
            end
        end
        gp.delete();
        foreach (got_all[i]) if (got_all[i][7:0] == 8'h11) gp.push_back(got_all[i]);
        check("arb_pix_once", gp.size(), acc);
        check("arb_done", mon_done, 1);
        $display("arbitration: pixel accepts=%0d writes=%0d", acc, got_all.size());

        // Reset mid-fill after two writes of a 4x4.
        send_cmd(50, 50, 4, 4, 8'h33);
        step();
        check("rst_mid_we", fb_write_enable, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_state", {fb_write_enable, busy, cmd_ready, pix_ready}, 4'b0011);
        step(); step();
        reset = 1'b1;
        step();
        clear_all();
        send_cmd(100, 100, 2, 1, 8'h55);
        wait_idle();
        compare_q("rst_new_fill", got_all, '{{9'd100, 8'd100, 8'h55}, {9'd101, 8'd100, 8'h55}});
        $display("reset mid-fill: restart writes=%0d", got_all.size());

        // Host pixels at and inside the boundary.
        pix_x = 9'd320; pix_y = 8'd0; pix_data = 8'h01; pix_valid = 1'b1;
        check("pix_oob_x_ready", pix_ready, 1'b1);
        step();
        pix_x = 9'd0; pix_y = 8'd200;
        check("pix_oob_x_we", fb_write_enable, 1'b0);
        check("pix_oob_y_ready", pix_ready, 1'b1);
        step();
        pix_x = 9'd319; pix_y = 8'd199; pix_data = 8'h7F;
        check("pix_oob_y_we", fb_write_enable, 1'b0);
        step();
        pix_valid = 1'b0;
        check("pix_corner", {fb_write_enable, fb_write_x, fb_write_y, fb_write_data},
              {1'b1, 9'd319, 8'd199, 8'h7F});
        step();
        check("pix_corner_once", fb_write_enable, 1'b0);
        $display("host pixel boundary done");

        // Randomized mixed traffic against the model.
        clear_all();
        for (int k = 0; k < 3000; k++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_x = 9'($urandom_range(0, 330)); cmd_y = 8'($urandom_range(0, 205));
            cmd_w = 9'($urandom_range(0, 8));   cmd_h = 8'($urandom_range(0, 5));
            cmd_color = 8'h80 | 8'($urandom_range(0, 127));
            pix_valid = ($urandom_range(0, 1) == 1);
            pix_x = 9'($urandom_range(0, 325)); pix_y = 8'($urandom_range(0, 205));
            pix_data = 8'($urandom_range(0, 127));
            if (cmd_valid && cmd_ready) model_cmd(cmd_x, cmd_y, cmd_w, cmd_h, cmd_color);
            if (pix_valid && pix_ready) model_pix(pix_x, pix_y, pix_data);
            step();
        end
        cmd_valid = 1'b0;
        pix_valid = 1'b0;
        wait_idle();
        gf.delete(); gp.delete();
        foreach (got_all[i]) begin
            if (got_all[i][7]) gf.push_back(got_all[i]);
            else gp.push_back(got_all[i]);
        end
        compare_q("rand_fill", gf, exp_fill);
        compare_q("rand_pix", gp, exp_pix);
        check("rand_done", mon_done, exp_done);
        check("rand_err", mon_err, exp_err);
        $display("random: fill writes=%0d pixel writes=%0d done=%0d err=%0d",
                 gf.size(), gp.size(), mon_done, mon_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
